// File: rtl/hough_frame_ctrl_if.sv
// hough_frame_ctrl_if: pixel, mask, accumulator and status signals of the frame sequencer
interface hough_frame_ctrl_if #(
  parameter int AW = 18,
  parameter int ACCUM_WIDTH = 16
);
  logic frame_start, mask_reload;
  logic in_image_wr_en, in_image_full, pipe_image_wr_en, pipe_image_full;
  logic [23:0] in_image_din, pipe_image_din;
  logic in_mask_wr_en, in_mask_full, pipe_mask_wr_en, pipe_mask_full;
  logic [23:0] in_mask_din, pipe_mask_din;
  logic hough_done;
  logic [AW-1:0] accum_rd_addr;
  logic [ACCUM_WIDTH-1:0] accum_rd_data, out_din;
  logic out_wr_en, out_full, busy, frame_done, protocol_err;
  logic [15:0] frame_count;
  modport slave (
    input frame_start, mask_reload, in_image_wr_en, in_image_din, pipe_image_full,
          in_mask_wr_en, in_mask_din, pipe_mask_full, hough_done, accum_rd_data, out_full,
    output in_image_full, pipe_image_wr_en, pipe_image_din, in_mask_full, pipe_mask_wr_en,
           pipe_mask_din, accum_rd_addr, out_wr_en, out_din, busy, frame_done, frame_count,
           protocol_err
  );
  modport master (
    output frame_start, mask_reload, in_image_wr_en, in_image_din, pipe_image_full,
           in_mask_wr_en, in_mask_din, pipe_mask_full, hough_done, accum_rd_data, out_full,
    input in_image_full, pipe_image_wr_en, pipe_image_din, in_mask_full, pipe_mask_wr_en,
          pipe_mask_din, accum_rd_addr, out_wr_en, out_din, busy, frame_done, frame_count,
          protocol_err
  );
endinterface

// File: rtl/hough_frame_ctrl.sv
// hough_frame_ctrl: gates one frame into the pipeline FIFOs, then streams the accumulator out
module hough_frame_ctrl #(
  parameter int WIDTH = 720,
  parameter int HEIGHT = 540,
  parameter int RHO_RANGE = 1000,
  parameter int THETAS = 180,
  parameter int ACCUM_WIDTH = 16
) (
  input logic clock,
  input logic reset,
  hough_frame_ctrl_if.slave bus
);
  localparam int NBINS = RHO_RANGE * THETAS;
  localparam int NPIX = WIDTH * HEIGHT;
  localparam int AW = $clog2(NBINS);
  localparam int PW = AW + 1;
  localparam int CW = $clog2(NPIX + 1);
  localparam logic [PW-1:0] NB = NBINS[PW-1:0];
  localparam logic [CW-1:0] NP = NPIX[CW-1:0];
  typedef enum logic [2:0] {IDLE, LOAD, WAIT_HOUGH, DRAIN, DONE} state_t;
  state_t state, nxt;
  logic [CW-1:0] img_cnt, msk_cnt;
  logic [PW-1:0] rd_ptr, wr_cnt;
  logic [ACCUM_WIDTH-1:0] hold_data;
  logic [15:0] frame_count;
  logic mask_en, mask_loaded, done_lat, rd_vld, hold_vld, protocol_err;
  logic img_acc, msk_acc, img_wr, msk_wr, out_wr, issue, start;
  always_comb begin
    img_acc = state == LOAD && img_cnt < NP;
    msk_acc = state == LOAD && mask_en && msk_cnt < NP;
    img_wr = bus.in_image_wr_en && img_acc && !bus.pipe_image_full;
    msk_wr = bus.in_mask_wr_en && msk_acc && !bus.pipe_mask_full;
    out_wr = !bus.out_full && (hold_vld || rd_vld);
    issue = state == DRAIN && !bus.out_full && !hold_vld && rd_ptr < NB;
    start = state == IDLE && bus.frame_start;
  end
  always_comb begin
    nxt = state;
    case (state)
      IDLE:       nxt = bus.frame_start ? LOAD : IDLE;
      LOAD:       nxt = (img_cnt == NP && (!mask_en || msk_cnt == NP)) ? WAIT_HOUGH : LOAD;
      WAIT_HOUGH: nxt = done_lat ? DRAIN : WAIT_HOUGH;
      DRAIN:      nxt = wr_cnt == NB ? DONE : DRAIN;
      default:    nxt = IDLE;
    endcase
  end
  assign bus.pipe_image_wr_en = img_wr;
  assign bus.pipe_image_din = bus.in_image_din;
  assign bus.in_image_full = bus.pipe_image_full || !img_acc;
  assign bus.pipe_mask_wr_en = msk_wr;
  assign bus.pipe_mask_din = bus.in_mask_din;
  assign bus.in_mask_full = bus.pipe_mask_full || !msk_acc;
  assign bus.accum_rd_addr = rd_ptr[AW-1:0];
  assign bus.out_wr_en = out_wr;
  assign bus.out_din = hold_vld ? hold_data : rd_vld ? bus.accum_rd_data : '0;
  assign bus.busy = state != IDLE;
  assign bus.frame_done = state == DONE;
  assign bus.frame_count = frame_count;
  assign bus.protocol_err = protocol_err;
  always_ff @(posedge clock) begin
    if (reset) begin
      state <= IDLE;
      img_cnt <= '0;
      msk_cnt <= '0;
      rd_ptr <= '0;
      wr_cnt <= '0;
      hold_data <= '0;
      hold_vld <= 1'b0;
      rd_vld <= 1'b0;
      mask_en <= 1'b0;
      mask_loaded <= 1'b0;
      done_lat <= 1'b0;
      frame_count <= '0;
      protocol_err <= 1'b0;
    end else begin
      state <= nxt;
      mask_en <= start ? (bus.mask_reload || !mask_loaded) : mask_en;
      img_cnt <= start ? '0 : img_cnt + CW'(img_wr);
      msk_cnt <= start ? '0 : msk_cnt + CW'(msk_wr);
      rd_ptr <= start ? '0 : rd_ptr + PW'(issue);
      wr_cnt <= start ? '0 : wr_cnt + PW'(out_wr);
      // early hough_done is kept until the drain can use it
      done_lat <= state == IDLE ? (done_lat && !bus.frame_start) : (done_lat || bus.hough_done);
      mask_loaded <= mask_loaded || (state == LOAD && nxt == WAIT_HOUGH && mask_en);
      rd_vld <= issue;
      hold_vld <= (rd_vld && bus.out_full) || (hold_vld && bus.out_full);
      hold_data <= (rd_vld && bus.out_full) ? bus.accum_rd_data : hold_data;
      frame_count <= frame_count + 16'(state == DONE);
      protocol_err <= protocol_err || (bus.in_image_wr_en && !img_acc && bus.in_image_full)
                                   || (bus.in_mask_wr_en && !msk_acc && bus.in_mask_full);
    end
  end
endmodule

// File: tb/tb_hough_frame_ctrl.sv
// tb_hough_frame_ctrl: directed frames on a 4x2 image with a 6-bin accumulator preloaded 10..15
module tb_hough_frame_ctrl;
  logic clock = 1'b0;
  logic reset = 1'b1;
  int n_tests = 0;
  int n_fail = 0;
  logic [15:0] mem [6];
  hough_frame_ctrl_if #(.AW(3), .ACCUM_WIDTH(16)) bus ();
  hough_frame_ctrl #(.WIDTH(4), .HEIGHT(2), .RHO_RANGE(3), .THETAS(2), .ACCUM_WIDTH(16)) dut (
    .clock(clock), .reset(reset), .bus(bus.slave)
  );
  always #5 clock = ~clock;
  always @(posedge clock) bus.accum_rd_data <= (bus.accum_rd_addr < 3'd6) ? mem[bus.accum_rd_addr] : 16'd0;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  task automatic start(input logic r);
    @(negedge clock);
    bus.frame_start = 1'b1;
    bus.mask_reload = r;
    @(negedge clock);
    bus.frame_start = 1'b0;
    bus.mask_reload = 1'b0;
  endtask
  task automatic pulse_done();
    @(negedge clock);
    bus.hough_done = 1'b1;
    @(negedge clock);
    bus.hough_done = 1'b0;
  endtask
  task automatic load(input int ni, input int nm, input bit toggle, input int done_at,
                      output int wi, output int wm, output logic mf);
    int si = 0;
    int sm = 0;
    bit sent = 1'b0;
    wi = 0;
    wm = 0;
    mf = 1'b1;
    for (int c = 0; c < 200 && (si < ni || sm < nm); c++) begin
      @(negedge clock);
      bus.pipe_image_full = toggle && (c % 2 == 1);
      bus.in_image_wr_en = si < ni;
      bus.in_image_din = 24'h100 + 24'(si);
      bus.in_mask_wr_en = sm < nm;
      bus.in_mask_din = 24'h200 + 24'(sm);
      bus.hough_done = done_at >= 0 && si == done_at && !sent;
      if (bus.hough_done) sent = 1'b1;
      #1;
      mf &= bus.in_mask_full;
      if (bus.pipe_image_wr_en) begin
        check("img_din", 32'(bus.pipe_image_din), 32'h100 + 32'(si));
        si++;
        wi++;
      end
      if (bus.pipe_mask_wr_en) begin
        check("msk_din", 32'(bus.pipe_mask_din), 32'h200 + 32'(sm));
        sm++;
        wm++;
      end
    end
    @(negedge clock);
    bus.in_image_wr_en = 1'b0;
    bus.in_mask_wr_en = 1'b0;
    bus.pipe_image_full = 1'b0;
    bus.hough_done = 1'b0;
  endtask
  task automatic drain(input bit stall, input int stop, output int n, output int p);
    bit s2 = 1'b0;
    bit s5 = 1'b0;
    n = 0;
    p = 0;
    for (int c = 0; c < 100 && p == 0 && !(stop > 0 && n >= stop); c++) begin
      @(negedge clock);
      bus.out_full = stall && ((n == 2 && !s2) || (n == 5 && !s5));
      if (bus.out_full && n == 2) s2 = 1'b1;
      if (bus.out_full && n == 5) s5 = 1'b1;
      #1;
      if (bus.out_wr_en) begin
        check("bin", 32'(bus.out_din), 32'd10 + 32'(n));
        n++;
      end
      if (bus.frame_done) p++;
    end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout");
    $fatal(1);
  end
  initial begin
    int wi, wm, n, p;
    logic mf;
    for (int i = 0; i < 6; i++) mem[i] = 16'(10 + i);
    {bus.frame_start, bus.mask_reload, bus.in_image_wr_en, bus.in_mask_wr_en} = '0;
    {bus.pipe_image_full, bus.pipe_mask_full, bus.hough_done} = '0;
    bus.in_image_din = '0;
    bus.in_mask_din = '0;
    bus.out_full = 1'b1;
    repeat (3) @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    #1;
    check("rst_busy", 32'(bus.busy), 0);
    check("rst_img_full", 32'(bus.in_image_full), 1);
    check("rst_msk_full", 32'(bus.in_mask_full), 1);
    check("rst_count", 32'(bus.frame_count), 0);
    check("rst_perr", 32'(bus.protocol_err), 0);
    check("rst_fdone", 32'(bus.frame_done), 0);
    check("rst_pipe_wr", 32'(bus.pipe_image_wr_en), 0);
    // frame 1: first frame after reset loads the mask even with mask_reload=0
    start(1'b0);
    check("f1_busy", 32'(bus.busy), 1);
    load(8, 8, 1'b0, -1, wi, wm, mf);
    check("f1_img_writes", 32'(wi), 8);
    check("f1_msk_writes", 32'(wm), 8);
    repeat (4) @(negedge clock);
    check("f1_wait_busy", 32'(bus.busy), 1);
    check("f1_wait_fdone", 32'(bus.frame_done), 0);
    pulse_done();
    drain(1'b0, 0, n, p);
    check("f1_bins", 32'(n), 6);
    check("f1_pulses", 32'(p), 1);
    @(negedge clock);
    #1;
    check("f1_fdone_low", 32'(bus.frame_done), 0);
    check("f1_idle", 32'(bus.busy), 0);
    check("f1_count", 32'(bus.frame_count), 1);
    // frame 2: mask reuse, image backpressure, early done, drain stalls
    start(1'b0);
    load(8, 0, 1'b1, 3, wi, wm, mf);
    check("f2_img_writes", 32'(wi), 8);
    check("f2_msk_writes", 32'(wm), 0);
    check("f2_msk_full", 32'(mf), 1);
    check("f2_perr_pre", 32'(bus.protocol_err), 0);
    @(negedge clock);
    bus.in_image_wr_en = 1'b1;
    #1;
    check("f2_ninth_full", 32'(bus.in_image_full), 1);
    check("f2_ninth_wr", 32'(bus.pipe_image_wr_en), 0);
    @(posedge clock);
    #1;
    check("f2_perr", 32'(bus.protocol_err), 1);
    @(negedge clock);
    bus.in_image_wr_en = 1'b0;
    drain(1'b1, 0, n, p);
    check("f2_bins", 32'(n), 6);
    check("f2_pulses", 32'(p), 1);
    @(negedge clock);
    check("f2_count", 32'(bus.frame_count), 2);
    bus.out_full = 1'b1;
    // frame 3: reset after three drained bins
    start(1'b1);
    load(8, 8, 1'b0, -1, wi, wm, mf);
    check("f3_msk_writes", 32'(wm), 8);
    pulse_done();
    drain(1'b0, 3, n, p);
    check("f3_bins", 32'(n), 3);
    bus.out_full = 1'b0;
    reset = 1'b1;
    @(posedge clock);
    #1;
    check("mid_rst_busy", 32'(bus.busy), 0);
    check("mid_rst_count", 32'(bus.frame_count), 0);
    check("mid_rst_out_wr", 32'(bus.out_wr_en), 0);
    check("mid_rst_perr", 32'(bus.protocol_err), 0);
    @(negedge clock);
    reset = 1'b0;
    bus.out_full = 1'b1;
    // frame 4: mask must reload after reset
    start(1'b0);
    load(8, 8, 1'b0, -1, wi, wm, mf);
    check("f4_msk_writes", 32'(wm), 8);
    pulse_done();
    drain(1'b0, 0, n, p);
    check("f4_bins", 32'(n), 6);
    @(negedge clock);
    check("f4_count", 32'(bus.frame_count), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
